pcie_csr_mmio_slave: RTL

PCIE_CSR_MMIO_SLAVE -- requirements
Module: pcie_csr_mmio_slave

---
 rtl/pcie_csr_mmio_slave.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pcie_csr_mmio_slave.sv
// MMIO CSR slave: DFH, scratchpad and live/sticky PCIe status.
// One outstanding request; the response is held until consumed.
module pcie_csr_mmio_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h10000,
  parameter logic [63:0] DFH_VALUE   = 64'h3000_0000_0000_0020,
  parameter logic [63:0] SCRATCH_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [63:0] stat_in
);

  typedef enum logic {IDLE, RSP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        armed;
  logic        accept;
  logic        in_win;
  logic        aligned;
  logic        dec_err;
  logic        wr_ok;
  logic        unused_ok;
  logic [31:0] offset;
  logic [8:0]  idx;
  logic [63:0] be_mask;
  logic [63:0] rd_val;
  logic [63:0] scratch;
  logic [63:0] stat;
  logic [31:0] clr;

  assign offset    = req_addr - BASE_ADDR;
  assign in_win    = (offset[31:12] == 20'd0);
  assign aligned   = (req_addr[2:0] == 3'b000);
  assign dec_err   = !(in_win && aligned);
  assign idx       = offset[11:3];
  assign unused_ok = ^offset[2:0];
  assign accept    = req_valid && req_ready;
  assign wr_ok     = accept && req_write && !dec_err;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < 8; i++)
      be_mask[8*i +: 8] = {8{req_wstrb[i]}};
  end

  assign clr = (wr_ok && idx == 9'd2)
             ? (req_wdata[63:32] & be_mask[63:32])
             : 32'd0;

  always_comb begin
    rd_val = '0;
    case (idx)
      9'd0:    rd_val = DFH_VALUE;
      9'd1:    rd_val = scratch;
      9'd2:    rd_val = stat;
      default: rd_val = '0;
    endcase
  end

  // armed keeps req_ready low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)    state_nxt = RSP;
      RSP:  if (rsp_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = armed && (state == IDLE);
    rsp_valid = (state == RSP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (req_write || dec_err) ? 64'd0 : rd_val;
      rsp_err   <= dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scratch <= SCRATCH_RST;
    else if (wr_ok && idx == 9'd1)
      scratch <= (scratch & ~be_mask) | (req_wdata & be_mask);
  end

  // sticky half: a live set beats a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stat <= '0;
    else
      stat <= {(stat[63:32] & ~clr) | stat_in[63:32], stat_in[31:0]};
  end

endmodule
